sipo_deserializer: RTL

- Parametrised serial-in/parallel-out deserializer; successor to the fixed 8-bit, free-running-counter SIPO.
- Accepts a bit-strobed serial stream, assembles WIDTH-bit words with programmable bit order and resynchronisation, and presents them on a valid/ready parallel port with one-word buffering and overrun detection.
- Sits between line-decoder front end and word-level consumers in the decoder path.

---
 rtl/sipo_pkg.sv | 39 +++
 rtl/sipo_bit_counter.sv | 51 +++++
 rtl/sipo_deserializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//   Shared definitions for the serial-in/parallel-out deserializer.
//
//   Contents:
//     bit_order_e   - placement of the first received bit in the word
//     PARITY_EN     - 1 when the trailing parity bit is compiled in
//     frame_bits()  - serial bits per frame (data bits plus optional parity)
//     count_width() - width of the in-frame bit counter
//
//   Build option:
//     SIPO_PARITY_EN - when defined, every frame carries one trailing parity
//                      bit after the WIDTH data bits.
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,   // first received bit lands in bit 0
        ORDER_MSB_FIRST = 1'b1    // first received bit lands in bit WIDTH-1
    } bit_order_e;

`ifdef SIPO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Serial bits making up one frame.
    function automatic int frame_bits(input int width);
        return width + (PARITY_EN ? 1 : 0);
    endfunction

    // The counter runs 0..frame_bits-1, i.e. at most WIDTH, so it needs
    // enough bits to hold the value WIDTH.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : sipo_pkg

// File: rtl/sipo_bit_counter.sv
// -----------------------------------------------------------------------------
// sipo_bit_counter
//   Modulo-FRAME_BITS bit counter for the deserializer. Counts accepted
//   serial bits, wraps to 0 on the last bit of a frame and can be restarted
//   so that the current bit becomes bit 0 of a new frame.
//
//   Parameters:
//     FRAME_BITS - bits per frame (count runs 0..FRAME_BITS-1)
//     CNT_W      - counter width
//
//   Ports:
//     clock   in   rising-edge clock
//     resetN  in   asynchronous active-low reset, count -> 0
//     enable  in   a bit is accepted this cycle
//     restart in   current bit is bit 0 of a new frame; count -> 1
//     count   out  bits collected in the current frame
//     wrap    out  current accepted bit completes the frame (combinational)
// -----------------------------------------------------------------------------
module sipo_bit_counter #(
    parameter int FRAME_BITS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             enable,
    input  logic             restart,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    // A restart always begins a fresh frame, so it never completes one,
    // even if the count happened to be sitting on the last position.
    assign wrap = enable && !restart && (count == LAST);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (restart) begin
            count <= CNT_W'(1);
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule : sipo_bit_counter

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Parametrised serial-in/parallel-out deserializer. Assembles WIDTH-bit
//   words from a bit-strobed serial stream with programmable bit order and
//   frame resynchronisation, and presents them on a valid/ready port backed
//   by a single holding register with sticky overrun detection.
//
//   Build option:
//     SIPO_PARITY_EN - frame becomes WIDTH data bits plus one trailing parity
//                      bit; parityErr reports the parity check of the held
//                      word. Undefined: frame is WIDTH bits, parityErr is 0.
//
//   Parameters:
//     WIDTH      - word width, 2..32
//     MSB_FIRST  - 0: first bit lands in bit 0; 1: first bit in bit WIDTH-1
//     PARITY_ODD - parity sense with SIPO_PARITY_EN (0 even, 1 odd)
//
//   Ports:
//     clock         in   rising-edge clock
//     resetN        in   asynchronous active-low reset
//     serialIn      in   serial data bit
//     serialValid   in   bit strobe, serialIn sampled only when high
//     frameSync     in   with serialValid: current bit is bit 0 of a new word
//     clearOverrun  in   clears the sticky overrun flag
//     parallelOut   out  assembled word
//     outValid      out  parallelOut holds an unconsumed word
//     outReady      in   consumer takes the word when outValid && outReady
//     overrun       out  sticky: a completed word was dropped
//     parityErr     out  parity status of the word on parallelOut
//     bitCount      out  bits collected in the current frame
// -----------------------------------------------------------------------------
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       serialIn,
    input  logic                       serialValid,
    input  logic                       frameSync,
    input  logic                       clearOverrun,
    output logic [WIDTH-1:0]           parallelOut,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       overrun,
    output logic                       parityErr,
    output logic [$clog2(WIDTH+1)-1:0] bitCount
);

    localparam int         FRAME_BITS   = frame_bits(WIDTH);
    localparam int         CNT_W        = count_width(WIDTH);
    localparam int         POS_W        = $clog2(WIDTH);
    localparam bit_order_e ORDER        = (MSB_FIRST != 0) ? ORDER_MSB_FIRST
                                                           : ORDER_LSB_FIRST;
    localparam bit         PARITY_SENSE = (PARITY_ODD != 0);

    // Word bit position for a given in-frame slot.
    function automatic logic [POS_W-1:0] slot_to_pos(input logic [CNT_W-1:0] slot);
        if (ORDER == ORDER_MSB_FIRST) begin
            return POS_W'(WIDTH - 1 - int'(slot));
        end
        return POS_W'(slot);
    endfunction

    logic [WIDTH-1:0] shift_p0;     // partial word being assembled
    logic [CNT_W-1:0] slot_c;       // slot the current bit occupies
    logic [WIDTH-1:0] word_c;       // partial word with the current bit merged
    logic [WIDTH-1:0] done_word_c;  // word handed to the output on completion
    logic             frame_done;   // current bit completes a frame
    logic             restart_c;
    logic             load_c;
    logic             drop_c;

    assign restart_c = serialValid && frameSync;

    sipo_bit_counter #(
        .FRAME_BITS (FRAME_BITS),
        .CNT_W      (CNT_W)
    ) u_bit_counter (
        .clock   (clock),
        .resetN  (resetN),
        .enable  (serialValid),
        .restart (restart_c),
        .count   (bitCount),
        .wrap    (frame_done)
    );

    // A sync bit starts from an empty word in slot 0, discarding partial bits.
    // Slots at or beyond WIDTH carry the parity bit and are not stored.
    always_comb begin
        slot_c = frameSync ? '0 : bitCount;
        word_c = frameSync ? '0 : shift_p0;
        if (slot_c < CNT_W'(WIDTH)) begin
            word_c[slot_to_pos(slot_c)] = serialIn;
        end
    end

    // ---- stage 0: serial assembly ----
    // The shift register is emptied when a frame completes so the next frame
    // starts clean regardless of whether the word was loaded or dropped.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            shift_p0 <= '0;
        end else if (serialValid) begin
            shift_p0 <= frame_done ? '0 : word_c;
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err_c;
    logic perr_p1;

    // Completion happens on the parity bit, so the data bits are already in
    // the shift register and the current serial bit is the parity bit.
    assign done_word_c  = shift_p0;
    assign parity_err_c = ((^shift_p0) ^ serialIn) != PARITY_SENSE;
`else
    assign done_word_c  = word_c;
`endif

    // Load when the holding register is empty or being emptied this cycle;
    // otherwise the completed word is lost.
    assign load_c = frame_done && (!outValid || outReady);
    assign drop_c = frame_done && outValid && !outReady;

    // ---- stage 1: holding register ----
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            parallelOut <= '0;
            outValid    <= 1'b0;
        end else if (load_c) begin
            parallelOut <= done_word_c;
            outValid    <= 1'b1;
        end else if (outValid && outReady) begin
            outValid    <= 1'b0;
        end
    end

    // A fresh drop wins over a simultaneous clear.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (clearOverrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            perr_p1 <= 1'b0;
        end else if (load_c) begin
            perr_p1 <= parity_err_c;
        end
    end

    assign parityErr = perr_p1;
`else
    // Without a parity bit there is nothing to check; the sense is irrelevant.
    assign parityErr = 1'b0 & PARITY_SENSE;
`endif

endmodule : sipo_deserializer
